// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of a single-access SDRAM controller host interface.
// Port A (instruction fetch) and port B (data) share one controller; all outputs are registered.
module sdram_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int DRAIN_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic        a_wr_en,
  input  logic [1:0]  a_bytesel,
  output logic [15:0] a_rdata,
  output logic        a_compl,
  input  logic [31:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic        b_wr_en,
  input  logic [1:0]  b_bytesel,
  output logic [15:0] b_rdata,
  output logic        b_compl,
  output logic [31:0] h_addr,
  output logic [15:0] h_wdata,
  output logic        h_wr_en,
  output logic [1:0]  h_bytesel,
  input  logic [15:0] h_rdata,
  input  logic        h_compl,
  input  logic        h_config_done
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_CFG = 2'd0,
    IDLE     = 2'd1,
    BUSY     = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] drain_cnt;
  logic          owner;       // 1 = port B
  logic          last_grant;  // 1 = port B
  logic          a_req;
  logic          b_req;
  logic          grant_b;

  // Pick the winner among current requesters; only meaningful in IDLE.
  always_comb begin
    a_req = (a_bytesel != 2'b00);
    b_req = (b_bytesel != 2'b00);
    if (a_req && b_req) begin
      grant_b = (PRIORITY_MODE == 0) && !last_grant;
    end else begin
      grant_b = b_req;
    end
  end

  // Arbitration FSM with all host-side and port-side outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_CFG;
      drain_cnt  <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      h_addr     <= 32'h0;
      h_wdata    <= 16'h0;
      h_wr_en    <= 1'b0;
      h_bytesel  <= 2'b00;
      a_rdata    <= 16'h0;
      b_rdata    <= 16'h0;
      a_compl    <= 1'b0;
      b_compl    <= 1'b0;
    end else begin
      case (state)
        // h_compl is deliberately ignored here: it may belong to MRS or to an access aborted by reset.
        WAIT_CFG: begin
          h_bytesel <= 2'b00;
          a_compl   <= 1'b0;
          b_compl   <= 1'b0;
          if (!h_config_done) begin
            drain_cnt <= '0;
          end else if (drain_cnt == DRAIN_LAST) begin
            drain_cnt <= '0;
            state     <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        IDLE: begin
          if (a_req || b_req) begin
            owner      <= grant_b;
            last_grant <= grant_b;
            h_addr     <= grant_b ? b_addr    : a_addr;
            h_wdata    <= grant_b ? b_wdata   : a_wdata;
            h_wr_en    <= grant_b ? b_wr_en   : a_wr_en;
            h_bytesel  <= grant_b ? b_bytesel : a_bytesel;
            state      <= BUSY;
          end else begin
            h_bytesel <= 2'b00;
          end
        end
        BUSY: begin
          if (h_compl) begin
            h_bytesel <= 2'b00;
            state     <= DONE;
            if (owner) begin
              b_rdata <= h_rdata;
              b_compl <= 1'b1;
            end else begin
              a_rdata <= h_rdata;
              a_compl <= 1'b1;
            end
          end else begin
            state <= BUSY;
          end
        end
        DONE: begin
          a_compl   <= 1'b0;
          b_compl   <= 1'b0;
          h_bytesel <= 2'b00;
          state     <= IDLE;
        end
        default: begin
          state     <= WAIT_CFG;
          drain_cnt <= '0;
          h_bytesel <= 2'b00;
          a_compl   <= 1'b0;
          b_compl   <= 1'b0;
        end
      endcase
    end
  end

endmodule
